piso_serializer: RTL and testbench

Parallel-in serial-out transmitter; the transmit-side counterpart of the team's 4-bit SIPO capture register. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clk. With that ordering, a SIPO register clocked on the same edges and sampling only while serial_valid is high holds the original word after the last bit. It sits at the boundary between the parallel datapath and a 1-bit serial link.

---
 rtl/piso_serializer.sv | 133 +++++++++++++
 tb/tb_piso_serializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - MSB-first parallel-in serial-out transmitter with valid/ready load.
// Optional macro PISO_PARITY_EN appends an even-parity bit cycle after each data word.
module piso_serializer #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
  logic parity_q;
`else
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             accept;

  assign accept = load_valid && load_ready;
  assign busy   = serial_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (count == '0) begin
`ifdef PISO_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = accept ? S_SHIFT : S_IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: state_nxt = accept ? S_SHIFT : S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // load_ready is gated by rst so no handshake can complete during reset.
  always_comb begin
    load_ready = 1'b0;
    done       = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE:  load_ready = 1'b1;
        S_SHIFT: begin
`ifndef PISO_PARITY_EN
          load_ready = (count == '0);
          done       = (count == '0);
`endif
        end
`ifdef PISO_PARITY_EN
        S_PARITY: begin
          load_ready = 1'b1;
          done       = 1'b1;
        end
`endif
        default: load_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg        <= '0;
      count        <= '0;
      serial_out   <= IDLE_LEVEL;
      serial_valid <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else if (accept) begin
      // MSB goes straight to the pin; the register keeps the remaining bits.
      serial_out   <= parallel_in[WIDTH-1];
      serial_valid <= 1'b1;
      shreg        <= {parallel_in[WIDTH-2:0], 1'b0};
      count        <= CW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
      parity_q     <= ^parallel_in;
`endif
    end else begin
      case (state)
        S_SHIFT: begin
          if (count != '0) begin
            serial_out <= shreg[WIDTH-1];
            shreg      <= {shreg[WIDTH-2:0], 1'b0};
            count      <= count - CW'(1);
          end else begin
`ifdef PISO_PARITY_EN
            serial_out   <= parity_q;
            serial_valid <= 1'b1;
`else
            serial_out   <= IDLE_LEVEL;
            serial_valid <= 1'b0;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        S_PARITY: begin
          serial_out   <= IDLE_LEVEL;
          serial_valid <= 1'b0;
        end
`endif
        default: begin
          serial_out   <= IDLE_LEVEL;
          serial_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - Self-checking bench for piso_serializer against a bit-queue model.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FL  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = W;
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] parallel_in = '0;
  logic         load_ready, serial_out, serial_valid, done, busy;
  int           tests = 0;
  int           fails = 0;

  typedef struct {
    logic b;
    logic last;
  } sbit_t;
  sbit_t        q[$];
  logic [W-1:0] sipo = '0;
  wire  [4:0]   obs = {serial_out, serial_valid, done, busy, load_ready};

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .parallel_in (parallel_in),
    .serial_out  (serial_out),
    .serial_valid(serial_valid),
    .done        (done),
    .busy        (busy)
  );

  // Reference: queue of bits still to be presented, front = bit on the wire now.
  always @(posedge clk or posedge rst) begin
    bit acc;
    if (rst) begin
      q.delete();
    end else begin
      acc = load_valid && (q.size() <= 1);
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        for (int i = W - 1; i >= 0; i--) q.push_back('{b: parallel_in[i], last: (i == 0) && !PAR});
        if (PAR) q.push_back('{b: ^parallel_in, last: 1'b1});
      end
    end
  end

  always @(posedge clk) if (!rst && serial_valid) sipo <= {sipo[W-2:0], serial_out};

  function automatic logic [4:0] exp_vec();
    logic v;
    v = (q.size() > 0);
    return {v ? q[0].b : 1'b0, v, v ? q[0].last : 1'b0, v, !rst && (q.size() <= 1)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b1; parallel_in = 4'hF;
    repeat (2) begin
      @(negedge clk);
      if (obs !== 5'b0) begin fails++; $display("FAIL reset_state: got %b exp 00000", obs); end
      tests++;
    end
    rst = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    if (obs !== 5'b00001) begin fails++; $display("FAIL reset_release: got %b exp 00001", obs); end
    tests++;
  endtask

  task automatic test_single_frame();
    logic [15:0] cap = '0;
    int nval = 0, ndone = 0;
    logic [15:0] exp_cap;
    exp_cap = PAR ? 16'b1_0111 : 16'b1011;
    parallel_in = 4'b1011; load_valid = 1'b1;
    for (int c = 0; c < FL + 3; c++) begin
      @(negedge clk);
      if (obs !== exp_vec()) begin fails++; $display("FAIL single_cycle%0d: got %b exp %b", c, obs, exp_vec()); end
      tests++;
      if (serial_valid) begin cap = {cap[14:0], serial_out}; nval++; end
      if (done) ndone++;
      load_valid = 1'b0; parallel_in = W'($urandom);
    end
    if (cap !== exp_cap || nval != FL || ndone != 1) begin
      fails++; $display("FAIL single_bits: got %b/%0d/%0d exp %b/%0d/1", cap, nval, ndone, exp_cap, FL);
    end
    tests++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[2] = '{4'b1011, 4'b0110};
    logic [15:0]  cap = '0;
    logic [15:0]  exp_cap;
    int k = 0, ndone = 0, chk = -1;
    exp_cap = PAR ? 16'b10_1110_1100 : 16'b1011_0110;
    parallel_in = words[0]; load_valid = 1'b1;
    if (q.size() <= 1) k = 1;
    for (int c = 0; c < 2 * FL + 3; c++) begin
      @(negedge clk);
      if (obs !== exp_vec()) begin fails++; $display("FAIL b2b_cycle%0d: got %b exp %b", c, obs, exp_vec()); end
      tests++;
`ifndef PISO_PARITY_EN
      if (chk >= 0) begin
        if (sipo !== words[chk]) begin fails++; $display("FAIL b2b_sipo%0d: got %b exp %b", chk, sipo, words[chk]); end
        tests++;
        chk = -1;
      end
      if (done) chk = ndone;
`endif
      if (serial_valid) cap = {cap[14:0], serial_out};
      if (done) ndone++;
      if (k < 2) begin
        parallel_in = words[k]; load_valid = 1'b1;
        if (q.size() <= 1) k++;
      end else begin
        load_valid = 1'b0; parallel_in = W'($urandom);
      end
    end
    if (cap !== exp_cap || ndone != 2) begin
      fails++; $display("FAIL b2b_bits: got %b/%0d exp %b/2", cap, ndone, exp_cap);
    end
    tests++;
  endtask

  task automatic test_busy_reject();
    logic [15:0] cap = '0;
    logic [15:0] exp_cap;
    bit will_acc;
    exp_cap = PAR ? 16'b11_0000_0110 : 16'b1100_0011;
    parallel_in = 4'b1100; load_valid = 1'b1;
    will_acc = 1'b1;
    for (int c = 0; c < 2 * FL + 3; c++) begin
      @(negedge clk);
      if (obs !== exp_vec()) begin fails++; $display("FAIL reject_cycle%0d: got %b exp %b", c, obs, exp_vec()); end
      tests++;
      if (serial_valid) cap = {cap[14:0], serial_out};
      if (will_acc) load_valid = 1'b0;
      if (c == 1) begin
        if (load_ready !== 1'b0) begin fails++; $display("FAIL reject_ready: got %b exp 0", load_ready); end
        tests++;
        parallel_in = 4'b0011; load_valid = 1'b1;
      end
      will_acc = load_valid && (q.size() <= 1);
    end
    if (cap !== exp_cap) begin fails++; $display("FAIL reject_bits: got %b exp %b", cap, exp_cap); end
    tests++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    logic [15:0]  cap = '0;
    logic [15:0]  exp_cap;
    parallel_in = 4'b1111; load_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      load_valid = 1'b0;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    if (obs !== 5'b0) begin fails++; $display("FAIL rstmid_async: got %b exp 00000", obs); end
    tests++;
    @(negedge clk);
    if (obs !== 5'b0) begin fails++; $display("FAIL rstmid_hold: got %b exp 00000", obs); end
    tests++;
    rst = 1'b0;
    w = W'($urandom);
    exp_cap = PAR ? {11'b0, w, ^w} : {12'b0, w};
    parallel_in = w; load_valid = 1'b1;
    for (int c = 0; c < FL + 2; c++) begin
      @(negedge clk);
      if (obs !== exp_vec()) begin fails++; $display("FAIL rstmid_cycle%0d: got %b exp %b", c, obs, exp_vec()); end
      tests++;
      if (serial_valid) cap = {cap[14:0], serial_out};
      load_valid = 1'b0; parallel_in = W'($urandom);
    end
    if (cap !== exp_cap) begin fails++; $display("FAIL rstmid_bits: got %b exp %b", cap, exp_cap); end
    tests++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (obs !== exp_vec()) begin fails++; $display("FAIL random_cycle%0d: got %b exp %b", c, obs, exp_vec()); end
      tests++;
      load_valid  = ($urandom_range(0, 3) != 0);
      parallel_in = W'($urandom);
      rst         = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0; load_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
